// File: rtl/i2c_txn_arbiter.sv
// Two-requester round-robin arbiter and transaction sequencer for the reduced I2C master.
// Grants the master to one requester, drives its WR/RD level controls and write byte,
// counts completed bytes against the requested length and waits for master idle on release.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort RUN/STOP_WAIT after TIMEOUT_CYC cycles.
module i2c_txn_arbiter #(
  parameter int unsigned IDLE_GAP    = 4,      // min 1
  parameter int unsigned TIMEOUT_CYC = 500000  // min 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rnw,
  input  logic [15:0] req_len,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  byte_done,
  output logic [7:0]  rdata,
  output logic [1:0]  rdata_valid,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        m_wr,
  output logic        m_rd,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic [3:0]  m_main_state,
  input  logic [4:0]  m_i2c_state,
  input  logic        m_scl_fallingedge,
  input  logic        m_nack
);

  localparam int unsigned GapW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [2:0] {StIdle, StGrant, StRun, StStopWait, StGap} state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            sel_q, sel_d;      // index of the granted requester
  logic            prio_q, prio_d;    // requester favoured on a tie
  logic            rnw_q, rnw_d;
  logic [8:0]      len_q, len_d;      // 1..256 bytes
  logic [8:0]      cnt_q, cnt_d;
  logic            abort_q, abort_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [1:0]      byte_done_q, byte_done_d;
  logic [1:0]      rdata_valid_q, rdata_valid_d;
  logic [1:0]      done_q, done_d, err_q, err_d;
  logic            pick;
  logic [7:0]      len_byte;
  logic            byte_strobe;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC);
  logic [WdW-1:0] wdog_q, wdog_d;
`else
  // No watchdog: a hung master stalls the arbiter until reset.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Next-state, sequencing and output-pulse logic.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    sel_d         = sel_q;
    prio_d        = prio_q;
    rnw_d         = rnw_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    abort_d       = abort_q;
    gap_d         = gap_q;
    m_wr_d        = m_wr_q;
    m_rd_d        = m_rd_q;
    rdata_d       = rdata_q;
    byte_done_d   = 2'b00;
    rdata_valid_d = 2'b00;
    done_d        = 2'b00;
    err_d         = 2'b00;
    pick          = (req == 2'b11) ? prio_q : req[1];
    len_byte      = pick ? req_len[15:8] : req_len[7:0];
    // A byte is complete when data_0 finishes inside a read or write transfer.
    byte_strobe   = m_scl_fallingedge && (m_i2c_state == 5'd7) &&
                    ((m_main_state == 4'd3) || (m_main_state == 4'd4));

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          sel_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          rnw_d   = req_rnw[pick];
          len_d   = (len_byte == 8'd0) ? 9'd256 : {1'b0, len_byte};
          cnt_d   = 9'd0;
          abort_d = 1'b0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        m_wr_d  = ~rnw_q;
        m_rd_d  = rnw_q;
        state_d = StRun;
      end
      StRun: begin
        if (byte_strobe) begin
          cnt_d       = cnt_q + 9'd1;
          byte_done_d = gnt_q;
          if (rnw_q) begin
            rdata_d       = m_rdata;
            rdata_valid_d = gnt_q;
          end
        end
        if (m_nack) begin
          m_wr_d  = 1'b0;
          m_rd_d  = 1'b0;
          abort_d = 1'b1;
          state_d = StStopWait;
        end else if (m_scl_fallingedge && (m_i2c_state == 5'd0) && (cnt_q == len_q)) begin
          // Release only once the next byte starts so the last ack bit has completed.
          m_wr_d  = 1'b0;
          m_rd_d  = 1'b0;
          state_d = StStopWait;
        end
      end
      StStopWait: begin
        if (m_main_state == 4'd0) begin
          done_d  = gnt_q;
          err_d   = abort_q ? gnt_q : 2'b00;
          gnt_d   = 2'b00;
          prio_d  = ~sel_q;
          gap_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapW'(IDLE_GAP - 1)) state_d = StIdle;
        else                              gap_d   = gap_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase

`ifdef I2C_ARB_TIMEOUT_EN
    wdog_d = wdog_q;
    if (state_q == StGrant) begin
      wdog_d = '0;
    end else if ((state_q == StRun) || (state_q == StStopWait)) begin
      wdog_d = wdog_q + WdW'(1);
      // Expiry lands done/err TIMEOUT_CYC cycles after the GRANT cycle.
      if (wdog_q == WdW'(TIMEOUT_CYC - 2)) begin
        m_wr_d        = 1'b0;
        m_rd_d        = 1'b0;
        byte_done_d   = 2'b00;
        rdata_valid_d = 2'b00;
        done_d        = gnt_q;
        err_d         = gnt_q;
        gnt_d         = 2'b00;
        prio_d        = ~sel_q;
        gap_d         = '0;
        state_d       = StGap;
      end
    end
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      gnt_q         <= 2'b00;
      sel_q         <= 1'b0;
      prio_q        <= 1'b0;
      rnw_q         <= 1'b0;
      len_q         <= 9'd0;
      cnt_q         <= 9'd0;
      abort_q       <= 1'b0;
      gap_q         <= '0;
      m_wr_q        <= 1'b0;
      m_rd_q        <= 1'b0;
      rdata_q       <= 8'h00;
      byte_done_q   <= 2'b00;
      rdata_valid_q <= 2'b00;
      done_q        <= 2'b00;
      err_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      sel_q         <= sel_d;
      prio_q        <= prio_d;
      rnw_q         <= rnw_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      abort_q       <= abort_d;
      gap_q         <= gap_d;
      m_wr_q        <= m_wr_d;
      m_rd_q        <= m_rd_d;
      rdata_q       <= rdata_d;
      byte_done_q   <= byte_done_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Watchdog counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`endif

  // Write byte follows the granted requester; zero when nobody holds the master.
  always_comb begin
    m_wdata = 8'h00;
    if (gnt_q[0])      m_wdata = req_wdata[7:0];
    else if (gnt_q[1]) m_wdata = req_wdata[15:8];
  end

  assign gnt         = gnt_q;
  assign byte_done   = byte_done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign m_wr        = m_wr_q;
  assign m_rd        = m_rd_q;

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
Two-requester round-robin arbiter and transaction sequencer in front of the reduced I2C master.
- Grants the single master to one requester at a time.
- Drives the master's WR/RD level controls and write byte, and counts completed bytes against a requested length.
- Ends each transaction by releasing WR/RD, then waits for the master to return to idle before re-arbitrating.

Parameters:
IDLE_GAP, 4, clock cycles held in GAP after master returns idle before next grant (min 1)
TIMEOUT_CYC, 500000, watchdog limit in clock cycles for RUN+STOP_WAIT (used only with I2C_ARB_TIMEOUT_EN)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
req  in  2  level request per requester; hold until done
req_rnw  in  2  per requester: 1=read, 0=write; sampled at grant
req_len  in  16  per requester 8-bit byte count, [7:0]=req0, [15:8]=req1; sampled at grant; 0 means 256
req_wdata  in  16  per requester write byte, same packing; must be valid while granted
gnt  out  2  one-hot grant, high GRANT..STOP_WAIT
byte_done  out  2  1-cycle pulse to the granted requester per completed byte
rdata  out  8  last read byte
rdata_valid  out  2  1-cycle pulse with rdata, read transactions only
done  out  2  1-cycle pulse at transaction end
err  out  2  1-cycle pulse coincident with done on abort (NACK/timeout)
m_wr  out  1  master write enable
m_rd  out  1  master read enable
m_wdata  out  8  byte to master, mux of granted requester's req_wdata
m_rdata  in  8  byte from master
m_main_state  in  4  master top state: idle=0, read=3, write=4, stop=5
m_i2c_state  in  5  master bit state: data_7=0 ... data_0=7, ack=8
m_scl_fallingedge  in  1  1-cycle SCL falling-edge strobe
m_nack  in  1  1-cycle strobe: slave NACK seen

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, round-robin pointer favours requester 0.
- States: IDLE, GRANT, RUN, STOP_WAIT, GAP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the one not granted last.
  - Latch rnw and len (0 maps to 256, 9-bit counter); go to GRANT.
- GRANT (1 cycle): assert gnt. m_wr=~rnw, m_rd=rnw, registered, so they are high the cycle after entry. Go to RUN.
- RUN byte completion: m_scl_fallingedge && m_i2c_state==7 && m_main_state in {3,4}.
  - Increment count and pulse byte_done.
  - On reads, also capture m_rdata into rdata and pulse rdata_valid in the same cycle.
- RUN last byte: when count==len and the next strobe with m_i2c_state==0 arrives, drop m_wr/m_rd and go to STOP_WAIT. The ack bit of the last byte completes before release.
- RUN abort: on m_nack, drop m_wr/m_rd immediately, set abort flag, go to STOP_WAIT.
- STOP_WAIT: when m_main_state==0, pulse done (and err if abort flag), deassert gnt, update pointer, go to GAP.
- GAP: count IDLE_GAP cycles, then go to IDLE.
- Requests: dropping req mid-transaction is ignored; the transaction runs to len. req still high after done re-arbitrates normally, so the other requester wins if it is waiting.
- Simultaneous byte-completion and m_nack in the same cycle: count the byte and pulse byte_done, then abort.
- m_wdata: combinationally muxes req_wdata of the granted requester; 0 when no grant.
- Async reset mid-transaction: immediate return to reset values. No done is issued.

Optional Feature:
I2C_ARB_TIMEOUT_EN
- Defined: a watchdog counts cycles in RUN+STOP_WAIT and clears on GRANT. At TIMEOUT_CYC it forces m_wr=m_rd=0, pulses done+err, deasserts gnt and goes to GAP without waiting for master idle.
- Undefined: no counter is built; a hung master stalls the arbiter until reset.

Test Plan:
- req0 write len=3, wdata increments on byte_done -> m_wr high 1 cycle after gnt[0]; exactly 3 byte_done[0] pulses; m_wr low at the 4th data_7 falling edge; done[0] once master idle; err=0.
- req1 read len=2, slave returns 0xA5, 0x5A -> rdata_valid[1] twice with rdata 0xA5 then 0x5A; m_rd never high with gnt[0].
- req0 and req1 asserted in the same cycle, each held high for 2 transactions -> grant order 0,1,0,1. GAP between grants is at least IDLE_GAP=4 cycles.
- Write len=4 with slave NACK on byte 2 -> m_wr drops the cycle after m_nack; byte_done count 2; done[0] and err[0] in the same cycle.
- rst_n pulsed low mid-RUN -> gnt, m_wr, m_rd 0 asynchronously; no done. After release, a new req0 is granted.
- With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYC=1000 and master held out of idle -> done+err at cycle 1000 after GRANT; m_wr=0.
